sec_key_reader: RTL and testbench
=================================

// Module: sec_key_reader
// PURPOSE
//  Host-side initiator for the on-board security-key PAL. Issues a fixed sequence of read strobes
//  into the key window (SSER low, BA13=0, BA12=1, BR_W=1), steering the PAL state machine with BA[7:4].
//  Samples the returned SDRD bit once per strobe into a response word and compares it against an
//  expected signature. Sits between the boot/licence controller (start/pass) and the shared board bus.
// PARAMETERS
//  NUM_BITS      16  strobes per challenge = response width (1..32)
//  STROBE_CYC    3   cycles SSER held low per strobe; SDRD sampled on the last one (>=2)
//  RECOVER_CYC   1   cycles SSER held high between strobes (>=1)
//  EXPECTED      16'hA5C3  expected response word, NUM_BITS wide
// PORTS
//  clk        in   1         system clock, all logic rising-edge
//  rst        in   1         synchronous, active-high reset
//  start      in   1         pulse: begin a challenge; ignored unless idle
//  bus_req    out  1         request ownership of board bus
//  bus_gnt    in   1         bus granted; must stay high while bus_req is high
//  sser_n     out  1         key-window select, active low
//  ba13       out  1         address bit 13, driven 0 whenever bus owned
//  ba12       out  1         address bit 12, driven 1 whenever bus owned
//  ba_nib     out  4         BA[7:4] steering nibble for current strobe
//  br_w       out  1         read/write_n, driven 1 (read) whenever bus owned
//  sdrd       in   1         serial data bit returned by key PAL
//  busy       out  1         challenge in progress
//  done       out  1         one-cycle pulse at end of challenge
//  pass       out  1         response matched EXPECTED; held until next start
//  resp       out  NUM_BITS  captured response, bit i = sample of strobe i
// BEHAVIOUR
//  Reset: state IDLE; bus_req=0, sser_n=1, ba13=0, ba12=0, ba_nib=0, br_w=0, busy=0, done=0,
//  pass=0, resp=0; bit index and cycle counter cleared. All outputs registered.
//  FSM: IDLE -> REQ -> SETUP -> STROBE -> RECOVER -> (SETUP | CHECK) -> IDLE.
//   IDLE: start=1 -> REQ, busy=1, resp cleared, pass cleared, idx=0.
//   REQ: bus_req=1; waits indefinitely for bus_gnt. gnt seen -> SETUP next cycle.
//   SETUP (1 cyc): ba12=1, ba13=0, br_w=1, ba_nib=KEY_NIB[idx], sser_n=1 (address setup).
//   STROBE (STROBE_CYC): sser_n=0, address stable; last cycle samples sdrd into resp[idx].
//   RECOVER (RECOVER_CYC): sser_n=1, address held. idx==NUM_BITS-1 -> CHECK, else idx++ -> SETUP.
//   CHECK (1 cyc): bus_req=0, ba12/br_w/ba_nib return to 0; pass=(resp==EXPECTED); done=1; -> IDLE.
//  Strobe count per challenge exactly NUM_BITS; total latency start->done =
//   1 + grant_wait + NUM_BITS*(1+STROBE_CYC+RECOVER_CYC) + 1 cycles.
//  sser_n never low outside STROBE; address never changes while sser_n=0.
//  start while busy: ignored, no restart. start and done same cycle: start ignored.
//  bus_gnt dropping mid-challenge: protocol violation; block completes unaffected (not checked).
//  rst mid-strobe: sser_n=1 and bus released on the next edge; partial resp discarded.
//  KEY_NIB index wraps modulo table depth (16) when NUM_BITS>16.
// CONFIGURATION
//  SEC_KEY_RETRY_EN defined: on mismatch in CHECK, bus held, one full re-run from idx=0 (the PAL
//   resynchronises on its idle-walk nibbles); done/pass reported only after the second run, whose resp
//   is final. Counter flags at most one retry per start.
//  Not defined: single run; mismatch -> done=1, pass=0 immediately.
// STRUCTURE
//  Package sec_key_pkg: KEY_NIB_DEPTH=16, KEY_NIB[0:15] steering table (4'h2,4'h9,4'hA,4'h9,4'hA,
//   4'h2,4'h1,4'hA,4'h2,4'h9,4'hA,4'h2,4'h9,4'h1,4'hA,4'h2), state enum, KEY_WIN_BA13=0, KEY_WIN_BA12=1.
//  One sub-module: sec_key_strobe_timer (loadable down-counter + terminal-count flag for STROBE/RECOVER).
// TESTING
//  Bench uses a behavioural key-PAL model on sser_n/ba*/br_w/sdrd returning a known word.
//  1. Model returns 16'hA5C3, gnt after 4 cyc -> 16 strobes, resp=16'hA5C3, pass=1, done 1 cyc,
//     latency 1+4+16*5+1=86.
//  2. Model returns 16'hA5C2 -> pass=0, resp=16'hA5C2; with SEC_KEY_RETRY_EN 32 strobes, then pass=0.
//  3. Retry build, model wrong on first run only -> second run correct, pass=1 after 32 strobes.
//  4. start pulsed on every cycle of a challenge -> exactly one challenge, one done pulse.
//  5. rst asserted on 2nd STROBE cycle of bit 7 -> next cycle sser_n=1, bus_req=0, resp=0, busy=0.
//  6. Assertions throughout: sser_n=0 implies ba12=1, ba13=0, br_w=1 and ba_nib stable since SETUP.

Source files
------------

// File: rtl/sec_key_pkg.sv
// Shared constants for the security-key reader: FSM encodings, key-window address
// constants and the BA[7:4] steering table that walks the key PAL state machine.
package sec_key_pkg;

   localparam int unsigned KEY_NIB_DEPTH = 16;

   localparam logic KEY_WIN_BA13 = 1'b0;
   localparam logic KEY_WIN_BA12 = 1'b1;

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StReq     = 3'd1;
   localparam logic [2:0] StSetup   = 3'd2;
   localparam logic [2:0] StStrobe  = 3'd3;
   localparam logic [2:0] StRecover = 3'd4;
   localparam logic [2:0] StCheck   = 3'd5;

   function automatic logic [3:0] key_nib(input logic [3:0] i);
      logic [3:0] n;
      case (i)
         4'd0:    n = 4'h2;
         4'd1:    n = 4'h9;
         4'd2:    n = 4'hA;
         4'd3:    n = 4'h9;
         4'd4:    n = 4'hA;
         4'd5:    n = 4'h2;
         4'd6:    n = 4'h1;
         4'd7:    n = 4'hA;
         4'd8:    n = 4'h2;
         4'd9:    n = 4'h9;
         4'd10:   n = 4'hA;
         4'd11:   n = 4'h2;
         4'd12:   n = 4'h9;
         4'd13:   n = 4'h1;
         4'd14:   n = 4'hA;
         default: n = 4'h2;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/sec_key_strobe_timer.sv
// Loadable down-counter timing the STROBE and RECOVER phases; tc is high while the
// count sits at zero, i.e. on the last cycle of the loaded interval.
module sec_key_strobe_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             tc
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign tc = (cnt_q == '0);

endmodule

// File: rtl/sec_key_reader.sv
// Host-side initiator that strobes the key PAL window and checks the returned signature.
// Build option SEC_KEY_RETRY_EN: one full re-run on mismatch before reporting.
module sec_key_reader
   import sec_key_pkg::*;
#(
   parameter int unsigned          NUM_BITS    = 16,
   parameter int unsigned          STROBE_CYC  = 3,
   parameter int unsigned          RECOVER_CYC = 1,
   parameter logic [NUM_BITS-1:0]  EXPECTED    = 16'hA5C3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                bus_req,
   input  logic                bus_gnt,
   output logic                sser_n,
   output logic                ba13,
   output logic                ba12,
   output logic [3:0]          ba_nib,
   output logic                br_w,
   input  logic                sdrd,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [NUM_BITS-1:0] resp
);

`ifdef SEC_KEY_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   localparam int unsigned IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
   localparam int unsigned TMR_W = 8;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BITS - 1);

   logic [2:0]          state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [NUM_BITS-1:0] resp_q, resp_d;
   logic                pass_q, pass_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                retry_q, retry_d;
   logic                tmr_load, tmr_tc;
   logic [TMR_W-1:0]    tmr_val;
   logic                owned, req;
   logic [3:0]          nib_idx;

   sec_key_strobe_timer #(
      .WIDTH (TMR_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      resp_d   = resp_q;
      pass_d   = pass_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      retry_d  = retry_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         StIdle: begin
            // done_q high means a start coincided with the done pulse; drop it.
            if (start && !done_q) begin
               state_d = StReq;
               busy_d  = 1'b1;
               resp_d  = '0;
               pass_d  = 1'b0;
               idx_d   = '0;
               retry_d = 1'b0;
            end
         end
         StReq: begin
            if (bus_gnt) state_d = StSetup;
         end
         StSetup: begin
            state_d  = StStrobe;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(STROBE_CYC - 1);
         end
         StStrobe: begin
            if (tmr_tc) begin
               resp_d[idx_q] = sdrd;
               state_d       = StRecover;
               tmr_load      = 1'b1;
               tmr_val       = TMR_W'(RECOVER_CYC - 1);
            end
         end
         StRecover: begin
            if (tmr_tc) begin
               if (idx_q == LAST_IDX) begin
                  // Retry goes straight back to SETUP so the bus is never released.
                  if (RETRY_EN && !retry_q && (resp_q != EXPECTED)) begin
                     state_d = StSetup;
                     idx_d   = '0;
                     resp_d  = '0;
                     retry_d = 1'b1;
                  end else begin
                     state_d = StCheck;
                  end
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = StSetup;
               end
            end
         end
         StCheck: begin
            state_d = StIdle;
            pass_d  = (resp_q == EXPECTED);
            done_d  = 1'b1;
            busy_d  = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   // Bus-side outputs are registered from the next state so they align with the state.
   always_comb begin
      owned   = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StRecover);
      req     = owned || (state_d == StReq);
      nib_idx = 4'(32'(idx_d) % KEY_NIB_DEPTH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         resp_q  <= '0;
         pass_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         retry_q <= 1'b0;
         bus_req <= 1'b0;
         sser_n  <= 1'b1;
         ba13    <= 1'b0;
         ba12    <= 1'b0;
         ba_nib  <= 4'h0;
         br_w    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         resp_q  <= resp_d;
         pass_q  <= pass_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         retry_q <= retry_d;
         bus_req <= req;
         sser_n  <= (state_d != StStrobe);
         ba13    <= owned ? KEY_WIN_BA13 : 1'b0;
         ba12    <= owned ? KEY_WIN_BA12 : 1'b0;
         ba_nib  <= owned ? key_nib(nib_idx) : 4'h0;
         br_w    <= owned;
      end
   end

   assign resp = resp_q;
   assign pass = pass_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_sec_key_reader.sv
// Self-checking bench for sec_key_reader with a behavioural bus arbiter and key-PAL model.
module tb_sec_key_reader;

   typedef struct {
      logic [15:0] resp;
      logic        pass;
      int          lat;
      int          strobes;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        bus_req, bus_gnt, sser_n, ba13, ba12, br_w, sdrd;
   logic [3:0]  ba_nib;
   logic        busy, done, pass;
   logic [15:0] resp;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int start_edge;
   int gnt_delay = 0;
   exp_t sb[$];

   // Model state, written only by the model process.
   int         strobe_cnt, strobe_cyc, viol_cnt, req_cnt, run;
   logic       prev_sser;
   logic [3:0] setup_nib;
   logic [15:0] run_word [2];
   logic [3:0] key_tab [16] = '{4'h2, 4'h9, 4'hA, 4'h9, 4'hA, 4'h2, 4'h1, 4'hA,
                                4'h2, 4'h9, 4'hA, 4'h2, 4'h9, 4'h1, 4'hA, 4'h2};

   sec_key_reader dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bus_req (bus_req),
      .bus_gnt (bus_gnt),
      .sser_n  (sser_n),
      .ba13    (ba13),
      .ba12    (ba12),
      .ba_nib  (ba_nib),
      .br_w    (br_w),
      .sdrd    (sdrd),
      .busy    (busy),
      .done    (done),
      .pass    (pass),
      .resp    (resp)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Arbiter grants after gnt_delay cycles of request; PAL answers one bit per strobe.
   always @(negedge clk) begin
      if (rst) begin
         strobe_cnt = 0; strobe_cyc = 0; viol_cnt = 0; req_cnt = 0;
         bus_gnt = 1'b0; prev_sser = 1'b1; sdrd = 1'b0; setup_nib = 4'h0;
      end else begin
         if (bus_req) begin
            if (req_cnt >= gnt_delay) bus_gnt = 1'b1;
            req_cnt++;
         end else begin
            bus_gnt = 1'b0;
            req_cnt = 0;
         end
         if (!sser_n) begin
            if (prev_sser) begin
               if (ba_nib !== key_tab[strobe_cnt % 16]) viol_cnt++;
               run = (strobe_cnt >= 16) ? 1 : 0;
               sdrd = run_word[run][strobe_cnt % 16];
               strobe_cnt++;
               strobe_cyc = 1;
            end else begin
               strobe_cyc++;
            end
            if (ba12 !== 1'b1 || ba13 !== 1'b0 || br_w !== 1'b1 || ba_nib !== setup_nib)
               viol_cnt++;
         end else if (ba12 === 1'b1) begin
            setup_nib = ba_nib;
         end
         prev_sser = sser_n;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic launch();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start_edge = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({bus_req, sser_n, ba13, ba12, br_w} !== 5'b01000) begin
         n_fail++;
         $display("FAIL reset_bus got %b want 01000", {bus_req, sser_n, ba13, ba12, br_w});
      end
      n_checks++;
      if (ba_nib !== 4'h0) begin n_fail++; $display("FAIL reset_nib got %h want 0", ba_nib); end
      n_checks++;
      if ({busy, done, pass} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_status got %b want 000", {busy, done, pass});
      end
      n_checks++;
      if (resp !== 16'h0) begin n_fail++; $display("FAIL reset_resp got %h want 0", resp); end
   endtask

   task automatic test_match();
      bit seen;
      exp_t e;
      do_reset();
      gnt_delay = 4;
      run_word[0] = 16'hA5C3;
      run_word[1] = 16'hA5C3;
      sb.push_back('{resp: 16'hA5C3, pass: 1'b1, lat: 86, strobes: 16});
      launch();
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL match_busy got %b want 1", busy); end
      wait_done(400, seen);
      e = sb.pop_front();
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL match_done got timeout want done");
      end else begin
         n_checks++;
         if (resp !== e.resp) begin n_fail++; $display("FAIL match_resp got %h want %h", resp, e.resp); end
         n_checks++;
         if (pass !== e.pass) begin n_fail++; $display("FAIL match_pass got %b want %b", pass, e.pass); end
         n_checks++;
         if (cyc - start_edge != e.lat) begin
            n_fail++;
            $display("FAIL match_latency got %0d want %0d", cyc - start_edge, e.lat);
         end
         n_checks++;
         if (strobe_cnt != e.strobes) begin
            n_fail++;
            $display("FAIL match_strobes got %0d want %0d", strobe_cnt, e.strobes);
         end
         n_checks++;
         if (viol_cnt != 0) begin n_fail++; $display("FAIL match_addr got %0d violations want 0", viol_cnt); end
         repeat (3) @(negedge clk);
         n_checks++;
         if ({done, pass, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL match_after got %b want 010", {done, pass, busy});
         end
      end
   endtask

   task automatic test_mismatch();
      bit seen;
      exp_t e;
      do_reset();
      gnt_delay = 2;
      run_word[0] = 16'hA5C2;
      run_word[1] = 16'hA5C2;
`ifdef SEC_KEY_RETRY_EN
      sb.push_back('{resp: 16'hA5C2, pass: 1'b0, lat: 1 + 2 + 160 + 1, strobes: 32});
`else
      sb.push_back('{resp: 16'hA5C2, pass: 1'b0, lat: 1 + 2 + 80 + 1, strobes: 16});
`endif
      launch();
      wait_done(600, seen);
      e = sb.pop_front();
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL mismatch_done got timeout want done");
      end else begin
         n_checks++;
         if ({resp, pass} !== {e.resp, e.pass}) begin
            n_fail++;
            $display("FAIL mismatch_result got %h/%b want %h/%b", resp, pass, e.resp, e.pass);
         end
         n_checks++;
         if (cyc - start_edge != e.lat) begin
            n_fail++;
            $display("FAIL mismatch_latency got %0d want %0d", cyc - start_edge, e.lat);
         end
         n_checks++;
         if (strobe_cnt != e.strobes) begin
            n_fail++;
            $display("FAIL mismatch_strobes got %0d want %0d", strobe_cnt, e.strobes);
         end
         n_checks++;
         if (viol_cnt != 0) begin n_fail++; $display("FAIL mismatch_addr got %0d violations want 0", viol_cnt); end
      end
   endtask

`ifdef SEC_KEY_RETRY_EN
   task automatic test_retry();
      bit seen;
      exp_t e;
      do_reset();
      gnt_delay = 0;
      run_word[0] = 16'hA5C2;
      run_word[1] = 16'hA5C3;
      sb.push_back('{resp: 16'hA5C3, pass: 1'b1, lat: 1 + 0 + 160 + 1, strobes: 32});
      launch();
      wait_done(600, seen);
      e = sb.pop_front();
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL retry_done got timeout want done");
      end else begin
         n_checks++;
         if ({resp, pass} !== {e.resp, e.pass}) begin
            n_fail++;
            $display("FAIL retry_result got %h/%b want %h/%b", resp, pass, e.resp, e.pass);
         end
         n_checks++;
         if (cyc - start_edge != e.lat || strobe_cnt != e.strobes) begin
            n_fail++;
            $display("FAIL retry_timing got %0d/%0d want %0d/%0d", cyc - start_edge, strobe_cnt,
                     e.lat, e.strobes);
         end
      end
   endtask
`endif

   task automatic test_start_spam();
      int dn = 0;
      bit seen = 1'b0;
      exp_t e;
      do_reset();
      gnt_delay = 1;
      run_word[0] = 16'hA5C3;
      run_word[1] = 16'hA5C3;
      sb.push_back('{resp: 16'hA5C3, pass: 1'b1, lat: 1 + 1 + 80 + 1, strobes: 16});
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start_edge = cyc;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            dn++;
         end
      end
      e = sb.pop_front();
      n_checks++;
      if (seen && cyc - start_edge != e.lat) begin
         n_fail++;
         $display("FAIL spam_latency got %0d want %0d", cyc - start_edge, e.lat);
      end else if (!seen) begin
         n_fail++;
         $display("FAIL spam_latency got timeout want %0d", e.lat);
      end
      // start still high across the edge following done; it must be ignored.
      @(negedge clk);
      n_checks++;
      if ({busy, bus_req} !== 2'b00) begin
         n_fail++;
         $display("FAIL spam_restart got busy/req %b want 00", {busy, bus_req});
      end
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1) dn++;
      end
      n_checks++;
      if (dn != 1) begin n_fail++; $display("FAIL spam_done_pulses got %0d want 1", dn); end
      n_checks++;
      if (strobe_cnt != e.strobes || resp !== e.resp) begin
         n_fail++;
         $display("FAIL spam_result got %0d/%h want %0d/%h", strobe_cnt, resp, e.strobes, e.resp);
      end
   endtask

   task automatic test_reset_mid();
      bit hit = 1'b0;
      do_reset();
      gnt_delay = 0;
      run_word[0] = 16'hA5C3;
      run_word[1] = 16'hA5C3;
      launch();
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         #1;
         if (strobe_cnt == 8 && strobe_cyc == 2 && sser_n === 1'b0) hit = 1'b1;
      end
      n_checks++;
      if (!hit) begin
         n_fail++;
         $display("FAIL rstmid_reach got timeout want bit7 strobe");
      end else begin
         n_checks++;
         if (resp === 16'h0) begin n_fail++; $display("FAIL rstmid_partial got %h want nonzero", resp); end
         rst = 1'b1;
         @(negedge clk);
         n_checks++;
         if ({sser_n, bus_req, busy} !== 3'b100 || resp !== 16'h0) begin
            n_fail++;
            $display("FAIL rstmid_state got sser/req/busy %b resp %h want 100 resp 0000",
                     {sser_n, bus_req, busy}, resp);
         end
         rst = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_match();
      test_mismatch();
`ifdef SEC_KEY_RETRY_EN
      test_retry();
`endif
      test_start_spam();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
